// File: rtl/cic_pkg.sv
// Shared constants, width helper and warm-up state encoding for the sinc^3 decimator.
package cic_pkg;
  localparam int CIC_ORDER = 3;

  function automatic int cic_acc_w(input int log2_osr);
    return CIC_ORDER * log2_osr + 2;
  endfunction

  typedef enum logic {WARMUP, RUN} warm_state_t;
endpackage

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: y = x - x_prev, where the delay loads x on each enabled edge.
module cic_comb_stage #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  logic [W-1:0] d;

  assign y = x - d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   d <= '0;
    else if (en) d <= x;
  end
endmodule

// File: rtl/cic3_decimator.sv
// Third-order CIC decimator: 1-bit bitstream in, full-precision signed PCM out at 1/OSR rate.
module cic3_decimator
  import cic_pkg::*;
#(
  parameter int LOG2_OSR = 6
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  bs_in,
  input  logic                                  bs_valid,
  output logic signed [cic_acc_w(LOG2_OSR)-1:0] dout,
  output logic                                  dout_valid
);
  localparam int ACC_W = cic_acc_w(LOG2_OSR);

  logic [ACC_W-1:0]                 x, i1, i2, i3;
  logic [LOG2_OSR-1:0]              phase;
  logic                             dec;
  logic [CIC_ORDER:0][ACC_W-1:0]    cmb;
  warm_state_t                      state, state_nxt;
  logic [1:0]                       cnt, cnt_nxt;
  logic                             vld_nxt;

  assign x = bs_in ? ACC_W'(1) : '1;

  // Integrators wrap modulo 2**ACC_W; the comb differences undo the wrap exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1    <= '0;
      i2    <= '0;
      i3    <= '0;
      phase <= '0;
      dec   <= 1'b0;
    end else begin
      dec <= bs_valid && (phase == '1);
      if (bs_valid) begin
        i1    <= i1 + x;
        i2    <= i2 + i1;
        i3    <= i3 + i2;
        phase <= phase + 1'b1;
      end
    end
  end

  assign cmb[0] = i3;

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk   (clk),
      .reset (reset),
      .en    (dec),
      .x     (cmb[k]),
      .y     (cmb[k+1])
    );
  end

  // The first three comb outputs still carry start-up transient, so they are not flagged valid.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vld_nxt   = 1'b0;
    if (dec) begin
      if (state == RUN) begin
        vld_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd2) state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= WARMUP;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dout_valid <= vld_nxt;
      if (dec) dout <= cmb[CIC_ORDER];
    end
  end
endmodule
